counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, number of queued commands (power of two, at least 2).
REQ-002 Parameter: LEN_W, 4, width of the run-length field.
REQ-003 Port: Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: nReset  in  1  asynchronous, active-low reset.
REQ-005 Port: CmdValid  in  1  command offered this cycle.
REQ-006 Port: CmdReady  out  1  command FIFO can accept a command (not full).
REQ-007 Port: CmdMode  in  1  counter mode to apply during RUN.
REQ-008 Port: CmdClear  in  1  1 = clear the counter before RUN.
REQ-009 Port: CmdLen  in  LEN_W  number of RUN cycles; 0 is legal.
REQ-010 Port: Abort  in  1  synchronous request to end the active command early.
REQ-011 Port: Count  in  3  current value from the driven counter.
REQ-012 Port: M  out  1  mode select to the counter.
REQ-013 Port: CntnReset  out  1  active-low clear to the counter.
REQ-014 Port: Busy  out  1  FSM not IDLE, or FIFO not empty.
REQ-015 Port: Done  out  1  one-cycle completion pulse.
REQ-016 Port: LastCount  out  3  Count captured at completion.

Function
REQ-017 Push when CmdValid=1 and CmdReady=1 at a clock edge; {CmdMode, CmdClear, CmdLen} enter the FIFO in order.
REQ-018 CmdReady SHALL be decoded from the registered FIFO occupancy only; a pop in the same cycle does not make a full FIFO accept.
REQ-019 Push into a non-full FIFO in the same cycle as a pop SHALL perform both; occupancy is unchanged.
REQ-020 FSM states: IDLE, CLEAR, RUN, DONE.
REQ-021 IDLE with FIFO non-empty: pop the head; next state CLEAR if CmdClear=1; else RUN if CmdLen is nonzero; else DONE.
REQ-022 IDLE with FIFO empty: stay in IDLE.
REQ-023 CLEAR lasts exactly 1 cycle, with CntnReset=0; next state RUN if CmdLen is nonzero, else DONE.
REQ-024 RUN lasts exactly CmdLen cycles, using a down-counter loaded at the pop; next state DONE.
REQ-025 M SHALL equal the popped CmdMode from the cycle after the pop; M holds that value until the next pop.
REQ-026 DONE lasts 1 cycle with Done=1; next state IDLE.
REQ-027 A new pop occurs on the following IDLE cycle at the earliest (minimum gap of one IDLE cycle between commands).
REQ-028 LastCount SHALL load Count, sampled at the edge entering DONE; LastCount holds otherwise.
REQ-029 Abort=1 in CLEAR or RUN: next state DONE, with Done pulsed and LastCount captured as usual.
REQ-030 Abort SHALL NOT alter the FIFO.
REQ-031 Abort in IDLE or DONE SHALL be ignored.
REQ-032 CntnReset SHALL be 1 in all states except CLEAR; it SHALL be decoded directly from registered state (glitch-free).
REQ-033 Busy=1 whenever the state is not IDLE or the FIFO occupancy is nonzero.

Reset
REQ-034 nReset=0 SHALL immediately and asynchronously force the following, independent of Clk: state IDLE, FIFO empty, M=0, Done=0, LastCount=0, run counter=0, CntnReset=0.
REQ-035 While nReset=0: CmdReady=0 and Busy=0.
REQ-036 Reset asserted mid-command SHALL discard the active command and all queued commands; no Done is produced.
REQ-037 After nReset deasserts, CntnReset=1 and CmdReady=1 from the first clock edge.

Verification
REQ-038 Reset, then push {M=1, Clear=1, Len=3} -> pop next edge; CntnReset=0 for 1 cycle; M=1 for 3 RUN cycles; Done=1 for 1 cycle; Busy=0 after.
REQ-039 Push {M=0, Clear=0, Len=0} -> IDLE, DONE, IDLE; no CLEAR cycle; no RUN cycle; Done pulses once.
REQ-040 Push 3 commands back-to-back while the first is running (FIFO_DEPTH=2) -> CmdReady=0 once 2 are queued; the third is accepted after a pop; all three complete in order with three Done pulses.
REQ-041 Abort asserted on the 2nd RUN cycle of a Len=6 command -> DONE on the next cycle; LastCount equals Count at that edge; the next queued command then starts normally.
REQ-042 nReset pulsed low during RUN with 1 command queued -> outputs take reset values immediately; no Done is produced; the queued command is lost; Busy=0.
REQ-043 Push in the same cycle as a pop with occupancy 1 -> occupancy stays 1; the pushed command executes next.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// Command handshake between a command source and the counter sequencer.
interface counter_sequencer_if #(
  parameter int LEN_W = 4
);
  logic             CmdValid;
  logic             CmdReady;
  logic             CmdMode;
  logic             CmdClear;
  logic [LEN_W-1:0] CmdLen;

  modport master (output CmdValid, output CmdMode, output CmdClear, output CmdLen,
                  input  CmdReady);
  modport slave  (input  CmdValid, input  CmdMode, input  CmdClear, input  CmdLen,
                  output CmdReady);
endinterface

// File: rtl/counter_sequencer.sv
// Counter sequencer: queues {mode, clear, len} commands in a small FIFO and
// plays each one out as an optional 1-cycle CLEAR, len RUN cycles and a
// 1-cycle DONE pulse, capturing the driven counter's value on completion.
// The interface LEN_W must match this module's LEN_W.
module counter_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int LEN_W      = 4
) (
  input  logic                Clk,
  input  logic                nReset,
  counter_sequencer_if.slave  cmd,
  input  logic                Abort,
  input  logic [2:0]          Count,
  output logic                M,
  output logic                CntnReset,
  output logic                Busy,
  output logic                Done,
  output logic [2:0]          LastCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = LEN_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  // FIFO storage and pointers; depth is a power of two so pointers wrap freely
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             alive_q;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic             m_q, m_d;
  logic [2:0]       last_q, last_d;
  logic             cntn_q, cntn_d;

  logic             full, empty, push, pop;
  logic             head_mode, head_clr;
  logic [LEN_W-1:0] head_len;

  assign full  = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (occ_q == '0);

  // Ready comes from registered occupancy only; alive_q keeps it low until
  // the first edge after reset release.
  assign cmd.CmdReady = alive_q && !full;
  assign push = cmd.CmdValid && alive_q && !full;
  assign pop  = (state_q == S_IDLE) && !empty;

  assign {head_mode, head_clr, head_len} = mem_q[rd_ptr_q];

  assign M         = m_q;
  assign LastCount = last_q;
  assign CntnReset = cntn_q;
  assign Done      = (state_q == S_DONE);
  assign Busy      = (state_q != S_IDLE) || !empty;

  // FIFO pointer/occupancy update; simultaneous push and pop keeps occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO payload write; contents are don't-care while empty, so no reset
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd.CmdMode, cmd.CmdClear, cmd.CmdLen};
  end

  // Next state, run counter, mode latch and completion capture
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    m_d     = m_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          m_d   = head_mode;
          run_d = head_len;
          if (head_clr)             state_d = S_CLEAR;
          else if (head_len != '0)  state_d = S_RUN;
          else                      state_d = S_DONE;
        end
      end
      S_CLEAR: begin
        if (Abort || run_q == '0) state_d = S_DONE;
        else                      state_d = S_RUN;
      end
      S_RUN: begin
        run_d = Abort ? '0 : run_q - 1'b1;
        if (Abort || run_q <= LEN_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) last_d = Count;
    // Registered from next state so the counter clear is a clean flop output
    cntn_d = (state_d != S_CLEAR);
  end

  // State registers; reset discards active and queued commands
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      alive_q  <= 1'b0;
      run_q    <= '0;
      m_q      <= 1'b0;
      last_q   <= '0;
      cntn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      alive_q  <= 1'b1;
      run_q    <= run_d;
      m_q      <= m_d;
      last_q   <= last_d;
      cntn_q   <= cntn_d;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a completion scoreboard.
module tb_counter_sequencer;

  typedef struct {
    logic       mode;
    logic       clr;
    logic [3:0] len;
  } cmd_t;

  logic       Clk;
  logic       nReset;
  logic       Abort;
  logic [2:0] Count;
  logic       M, CntnReset, Busy, Done;
  logic [2:0] LastCount;

  int   checks = 0;
  int   errors = 0;
  int   clr_seen = 0;
  cmd_t sb[$];

  counter_sequencer_if #(.LEN_W(4)) cif();

  counter_sequencer #(.FIFO_DEPTH(2), .LEN_W(4)) dut (
    .Clk(Clk), .nReset(nReset), .cmd(cif), .Abort(Abort), .Count(Count),
    .M(M), .CntnReset(CntnReset), .Busy(Busy), .Done(Done), .LastCount(LastCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; at the following falling edge, score any completion, then
  // present a fresh Count for the next rising edge.
  task automatic tick();
    cmd_t e;
    @(posedge Clk);
    @(negedge Clk);
    if (nReset && !CntnReset) clr_seen++;
    if (Done === 1'b1) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_mode", 32'(M), 32'(e.mode));
        chk("done_lastcount", 32'(LastCount), 32'(Count));
        chk("done_clear_cycles", 32'(clr_seen), 32'(e.clr));
      end
      clr_seen = 0;
    end
    Count = 3'($urandom_range(0, 7));
  endtask

  task automatic push_cmd(input logic mode, input logic clr, input logic [3:0] len);
    cmd_t e;
    int n = 0;
    cif.CmdValid = 1'b1;
    cif.CmdMode  = mode;
    cif.CmdClear = clr;
    cif.CmdLen   = len;
    while (cif.CmdReady !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("push_ready_timeout", 32'(n < 100), 32'd1);
    e.mode = mode; e.clr = clr; e.len = len;
    sb.push_back(e);
    tick();
    cif.CmdValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((Busy !== 1'b0 || sb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    nReset = 1'b0;
    Abort  = 1'b0;
    Count  = 3'd0;
    cif.CmdValid = 1'b0;
    cif.CmdMode  = 1'b0;
    cif.CmdClear = 1'b0;
    cif.CmdLen   = 4'd0;

    // Reset values, before any clock edge
    #2;
    chk("rst_cntn", 32'(CntnReset), 32'd0);
    chk("rst_ready", 32'(cif.CmdReady), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_m", 32'(M), 32'd0);
    chk("rst_lastcount", 32'(LastCount), 32'd0);
    tick(); tick();
    chk("rst_ready_held", 32'(cif.CmdReady), 32'd0);
    nReset = 1'b1;
    tick();
    chk("post_rst_cntn", 32'(CntnReset), 32'd1);
    chk("post_rst_ready", 32'(cif.CmdReady), 32'd1);

    // Clear + 3 RUN cycles with mode 1
    push_cmd(1'b1, 1'b1, 4'd3);
    chk("t1_busy_queued", 32'(Busy), 32'd1);
    tick();
    chk("t1_clear_cntn", 32'(CntnReset), 32'd0);
    chk("t1_clear_m", 32'(M), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_run_cntn", 32'(CntnReset), 32'd1);
      chk("t1_run_m", 32'(M), 32'd1);
      chk("t1_run_done", 32'(Done), 32'd0);
    end
    tick();
    chk("t1_done", 32'(Done), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(Done), 32'd0);
    chk("t1_busy_after", 32'(Busy), 32'd0);

    // Zero-length, no clear: IDLE -> DONE -> IDLE
    push_cmd(1'b0, 1'b0, 4'd0);
    tick();
    chk("t2_done", 32'(Done), 32'd1);
    chk("t2_no_clear", 32'(CntnReset), 32'd1);
    tick();
    chk("t2_done_pulse", 32'(Done), 32'd0);
    chk("t2_busy_after", 32'(Busy), 32'd0);

    // Three commands while the first runs; FIFO fills at two
    push_cmd(1'b1, 1'b0, 4'd5);
    push_cmd(1'b0, 1'b1, 4'd2);
    push_cmd(1'b1, 1'b0, 4'd1);
    chk("t3_full_not_ready", 32'(cif.CmdReady), 32'd0);
    push_cmd(1'b0, 1'b0, 4'd3);
    drain("t3_drain_timeout");
    chk("t3_all_done", 32'(sb.size()), 32'd0);

    // Abort on the second RUN cycle; queued command still runs
    push_cmd(1'b1, 1'b0, 4'd6);
    push_cmd(1'b0, 1'b1, 4'd2);
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("t4_abort_done", 32'(Done), 32'd1);
    chk("t4_queued_kept", 32'(sb.size()), 32'd1);
    drain("t4_drain_timeout");

    // Abort while idle does nothing
    Abort = 1'b1;
    tick(); tick();
    Abort = 1'b0;
    chk("t4_idle_abort_busy", 32'(Busy), 32'd0);
    chk("t4_idle_abort_done", 32'(Done), 32'd0);

    // Reset mid-RUN with a command queued
    push_cmd(1'b1, 1'b0, 4'd8);
    push_cmd(1'b0, 1'b0, 4'd3);
    tick();
    nReset = 1'b0;
    #1;
    chk("t5_rst_cntn", 32'(CntnReset), 32'd0);
    chk("t5_rst_ready", 32'(cif.CmdReady), 32'd0);
    chk("t5_rst_busy", 32'(Busy), 32'd0);
    chk("t5_rst_done", 32'(Done), 32'd0);
    chk("t5_rst_m", 32'(M), 32'd0);
    chk("t5_rst_lastcount", 32'(LastCount), 32'd0);
    sb.delete();
    tick(); tick();
    nReset = 1'b1;
    tick();
    clr_seen = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("t5_queue_lost_busy", 32'(Busy), 32'd0);
    chk("t5_ready_back", 32'(cif.CmdReady), 32'd1);

    // Push while popping at occupancy 1
    push_cmd(1'b0, 1'b0, 4'd0);
    push_cmd(1'b1, 1'b0, 4'd1);
    chk("t6_ready_occ1", 32'(cif.CmdReady), 32'd1);
    tick();
    chk("t6_busy_queued", 32'(Busy), 32'd1);
    tick(); tick(); tick();
    chk("t6_busy_after", 32'(Busy), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
